// File: rtl/bm_packet_req_gen_pkg.sv
// Shared widths, FSM encoding and packet_req payload for bm_packet_req_gen.
package bm_packet_req_gen_pkg;

  localparam int unsigned PORT_ID_NBITS      = 4;
  localparam int unsigned BUF_PTR_NBITS      = 10;
  localparam int unsigned BUF_PTR_LSB_NBITS  = 2;
  localparam int unsigned DATA_PATH_NBYTES   = 16;
  localparam int unsigned DATA_PATH_VB_NBITS = 4;
  localparam int unsigned LEN_NBITS          = 14;
  localparam int unsigned ED_CREDITS         = 8;
  localparam int unsigned CREDIT_NBITS       = $clog2(ED_CREDITS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT    = 2'd1,
    LL_WAIT = 2'd2
  } state_e;

  // One beat request towards the shared packet memory
  typedef struct packed {
    logic [PORT_ID_NBITS-1:0]      src_port_id;
    logic [PORT_ID_NBITS-1:0]      dst_port_id;
    logic                          sop;
    logic                          eop;
    logic [DATA_PATH_VB_NBITS-1:0] valid_bytes;
    logic [BUF_PTR_NBITS-1:0]      buf_ptr;
    logic [BUF_PTR_LSB_NBITS-1:0]  buf_ptr_lsb;
  } preq_t;

endpackage

// File: rtl/bm_credit_counter.sv
// Saturating up/down credit counter with reset-to-init value and nonzero flag.
module bm_credit_counter
  import bm_packet_req_gen_pkg::*;
#(
  parameter int unsigned CNT_NBITS = CREDIT_NBITS,
  parameter int unsigned INIT_VAL  = ED_CREDITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_dec,
  input  logic                 i_inc,
  output logic [CNT_NBITS-1:0] o_count,
  output logic                 o_nonzero_c
);

  logic [CNT_NBITS-1:0] r_count;

  // Simultaneous inc/dec cancel; inc saturates at the init value, dec at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= CNT_NBITS'(INIT_VAL);
    end else begin
      case ({i_inc, i_dec})
        2'b10: if (r_count != CNT_NBITS'(INIT_VAL)) r_count <= r_count + CNT_NBITS'(1);
        2'b01: if (r_count != '0) r_count <= r_count - CNT_NBITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_nonzero_c = (r_count != '0);

endmodule

// File: rtl/bm_packet_req_gen.sv
// Buffer-manager packet-read initiator: walks a descriptor's buffer chain and
// issues one packet_req per beat, gated by downstream ED credits.
// Optional ack shadow check enabled by defining BM_PREQ_ACK_CHECK_EN.
module bm_packet_req_gen
  import bm_packet_req_gen_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tm_bm_desc_valid,
  output logic                          tm_bm_desc_ready,
  input  logic [PORT_ID_NBITS-1:0]      tm_bm_desc_src_port_id,
  input  logic [PORT_ID_NBITS-1:0]      tm_bm_desc_dst_port_id,
  input  logic [BUF_PTR_NBITS-1:0]      tm_bm_desc_buf_ptr,
  input  logic [LEN_NBITS-1:0]          tm_bm_desc_len,
  output logic                          ll_rd_req,
  output logic [BUF_PTR_NBITS-1:0]      ll_rd_ptr,
  input  logic                          ll_rd_valid,
  input  logic [BUF_PTR_NBITS-1:0]      ll_rd_next_ptr,
  input  logic                          ed_bm_credit_return,
  output logic                          packet_req,
  output logic [PORT_ID_NBITS-1:0]      packet_req_src_port_id,
  output logic [PORT_ID_NBITS-1:0]      packet_req_dst_port_id,
  output logic                          packet_req_sop,
  output logic                          packet_req_eop,
  output logic [DATA_PATH_VB_NBITS-1:0] packet_req_valid_bytes,
  output logic [BUF_PTR_NBITS-1:0]      packet_req_buf_ptr,
  output logic [BUF_PTR_LSB_NBITS-1:0]  packet_req_buf_ptr_lsb,
  input  logic                          packet_ack_data_valid,
  input  logic [PORT_ID_NBITS-1:0]      packet_ack_port_id,
  input  logic                          packet_ack_sop,
  output logic                          err_ack_mismatch
);

  state_e                         r_state, w_state_nxt;

  logic [PORT_ID_NBITS-1:0]       r_src, w_src;
  logic [PORT_ID_NBITS-1:0]       r_dst, w_dst;
  logic [BUF_PTR_NBITS-1:0]       r_ptr, w_ptr;
  logic [BUF_PTR_LSB_NBITS-1:0]   r_lsb, w_lsb;
  logic [LEN_NBITS-1:0]           r_bytes_left, w_bytes_left;
  logic                           r_first, w_first;

  preq_t                          r_preq, w_preq;
  logic                           r_packet_req, w_packet_req;
  logic                           r_ll_rd_req, w_ll_rd_req;
  logic [BUF_PTR_NBITS-1:0]       r_ll_rd_ptr, w_ll_rd_ptr;
  logic                           r_desc_ready, w_desc_ready;

  logic                           w_issue;
  logic                           w_eop;
  logic                           w_credit_ok;
  logic [CREDIT_NBITS-1:0]        w_unused_credit_cnt;

  // Downstream ED credit pool: one credit per issued beat
  bm_credit_counter #(
    .CNT_NBITS (CREDIT_NBITS),
    .INIT_VAL  (ED_CREDITS)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .i_dec       (w_issue),
    .i_inc       (ed_bm_credit_return),
    .o_count     (w_unused_credit_cnt),
    .o_nonzero_c (w_credit_ok)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, packet context and registered-output next values
  always_comb begin
    w_state_nxt  = r_state;
    w_src        = r_src;
    w_dst        = r_dst;
    w_ptr        = r_ptr;
    w_lsb        = r_lsb;
    w_bytes_left = r_bytes_left;
    w_first      = r_first;
    w_preq       = r_preq;
    w_packet_req = 1'b0;
    w_ll_rd_req  = 1'b0;
    w_ll_rd_ptr  = r_ll_rd_ptr;
    w_issue      = 1'b0;
    w_eop        = (r_bytes_left <= LEN_NBITS'(DATA_PATH_NBYTES));

    case (r_state)
      IDLE: begin
        if (tm_bm_desc_valid && r_desc_ready) begin
          w_src        = tm_bm_desc_src_port_id;
          w_dst        = tm_bm_desc_dst_port_id;
          w_ptr        = tm_bm_desc_buf_ptr;
          w_lsb        = '0;
          w_bytes_left = tm_bm_desc_len;
          w_first      = 1'b1;
          w_state_nxt  = BEAT;
        end
      end
      BEAT: begin
        if (w_credit_ok) begin
          w_issue            = 1'b1;
          w_packet_req       = 1'b1;
          w_preq.src_port_id = r_src;
          w_preq.dst_port_id = r_dst;
          w_preq.sop         = r_first;
          w_preq.eop         = w_eop;
          w_preq.valid_bytes = w_eop ? r_bytes_left[DATA_PATH_VB_NBITS-1:0] : '0;
          w_preq.buf_ptr     = r_ptr;
          w_preq.buf_ptr_lsb = r_lsb;
          w_bytes_left       = w_eop ? '0 : r_bytes_left - LEN_NBITS'(DATA_PATH_NBYTES);
          w_first            = 1'b0;
          if (w_eop) begin
            w_state_nxt = IDLE;
          end else if (&r_lsb) begin
            w_ll_rd_req = 1'b1;
            w_ll_rd_ptr = r_ptr;
            w_state_nxt = LL_WAIT;
          end else begin
            w_lsb = r_lsb + BUF_PTR_LSB_NBITS'(1);
          end
        end
      end
      LL_WAIT: begin
        if (ll_rd_valid) begin
          w_ptr       = ll_rd_next_ptr;
          w_lsb       = '0;
          w_state_nxt = BEAT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_desc_ready = (w_state_nxt == IDLE);
  end

  // Packet context and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_ptr        <= '0;
      r_lsb        <= '0;
      r_bytes_left <= '0;
      r_first      <= 1'b0;
      r_preq       <= '0;
      r_packet_req <= 1'b0;
      r_ll_rd_req  <= 1'b0;
      r_ll_rd_ptr  <= '0;
      r_desc_ready <= 1'b0;
    end else begin
      r_src        <= w_src;
      r_dst        <= w_dst;
      r_ptr        <= w_ptr;
      r_lsb        <= w_lsb;
      r_bytes_left <= w_bytes_left;
      r_first      <= w_first;
      r_preq       <= w_preq;
      r_packet_req <= w_packet_req;
      r_ll_rd_req  <= w_ll_rd_req;
      r_ll_rd_ptr  <= w_ll_rd_ptr;
      r_desc_ready <= w_desc_ready;
    end
  end

  assign tm_bm_desc_ready       = r_desc_ready;
  assign ll_rd_req              = r_ll_rd_req;
  assign ll_rd_ptr              = r_ll_rd_ptr;
  assign packet_req             = r_packet_req;
  assign packet_req_src_port_id = r_preq.src_port_id;
  assign packet_req_dst_port_id = r_preq.dst_port_id;
  assign packet_req_sop         = r_preq.sop;
  assign packet_req_eop         = r_preq.eop;
  assign packet_req_valid_bytes = r_preq.valid_bytes;
  assign packet_req_buf_ptr     = r_preq.buf_ptr;
  assign packet_req_buf_ptr_lsb = r_preq.buf_ptr_lsb;

`ifdef BM_PREQ_ACK_CHECK_EN
  logic                     r_sh_req;
  logic [PORT_ID_NBITS-1:0] r_sh_dst;
  logic                     r_sh_sop;
  logic                     r_err;
  logic                     w_ack_bad;

  // Shadow of the request issued last cycle; its ack is due now
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_req <= 1'b0;
      r_sh_dst <= '0;
      r_sh_sop <= 1'b0;
    end else begin
      r_sh_req <= r_packet_req;
      r_sh_dst <= r_preq.dst_port_id;
      r_sh_sop <= r_preq.sop;
    end
  end

  always_comb begin
    w_ack_bad = (packet_ack_data_valid != r_sh_req) ||
                (packet_ack_data_valid && r_sh_req &&
                 ((packet_ack_port_id != r_sh_dst) || (packet_ack_sop != r_sh_sop)));
  end

  // Sticky mismatch flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)            r_err <= 1'b0;
    else if (w_ack_bad) r_err <= 1'b1;
  end

  assign err_ack_mismatch = r_err;
`else
  logic w_unused_ack;
  assign w_unused_ack     = ^{packet_ack_data_valid, packet_ack_port_id, packet_ack_sop};
  assign err_ack_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_bm_packet_req_gen.sv
// Directed bench for bm_packet_req_gen: descriptor table plus credit/reset/ack sequences.
`timescale 1ns/1ps
module tb_bm_packet_req_gen;
  import bm_packet_req_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tm_bm_desc_valid = 1'b0;
  logic        tm_bm_desc_ready;
  logic [3:0]  tm_bm_desc_src_port_id = '0;
  logic [3:0]  tm_bm_desc_dst_port_id = '0;
  logic [9:0]  tm_bm_desc_buf_ptr = '0;
  logic [13:0] tm_bm_desc_len = '0;
  logic        ll_rd_req;
  logic [9:0]  ll_rd_ptr;
  logic        ll_rd_valid = 1'b0;
  logic [9:0]  ll_rd_next_ptr = '0;
  logic        ed_bm_credit_return;
  logic        packet_req;
  logic [3:0]  packet_req_src_port_id, packet_req_dst_port_id;
  logic        packet_req_sop, packet_req_eop;
  logic [3:0]  packet_req_valid_bytes;
  logic [9:0]  packet_req_buf_ptr;
  logic [1:0]  packet_req_buf_ptr_lsb;
  logic        packet_ack_data_valid = 1'b0;
  logic [3:0]  packet_ack_port_id = '0;
  logic        packet_ack_sop = 1'b0;
  logic        err_ack_mismatch;

  always #5 clk = ~clk;

  bm_packet_req_gen dut (
    .clk                    (clk),
    .rst                    (rst),
    .tm_bm_desc_valid       (tm_bm_desc_valid),
    .tm_bm_desc_ready       (tm_bm_desc_ready),
    .tm_bm_desc_src_port_id (tm_bm_desc_src_port_id),
    .tm_bm_desc_dst_port_id (tm_bm_desc_dst_port_id),
    .tm_bm_desc_buf_ptr     (tm_bm_desc_buf_ptr),
    .tm_bm_desc_len         (tm_bm_desc_len),
    .ll_rd_req              (ll_rd_req),
    .ll_rd_ptr              (ll_rd_ptr),
    .ll_rd_valid            (ll_rd_valid),
    .ll_rd_next_ptr         (ll_rd_next_ptr),
    .ed_bm_credit_return    (ed_bm_credit_return),
    .packet_req             (packet_req),
    .packet_req_src_port_id (packet_req_src_port_id),
    .packet_req_dst_port_id (packet_req_dst_port_id),
    .packet_req_sop         (packet_req_sop),
    .packet_req_eop         (packet_req_eop),
    .packet_req_valid_bytes (packet_req_valid_bytes),
    .packet_req_buf_ptr     (packet_req_buf_ptr),
    .packet_req_buf_ptr_lsb (packet_req_buf_ptr_lsb),
    .packet_ack_data_valid  (packet_ack_data_valid),
    .packet_ack_port_id     (packet_ack_port_id),
    .packet_ack_sop         (packet_ack_sop),
    .err_ack_mismatch       (err_ack_mismatch)
  );

  int total = 0;
  int bad   = 0;

  // Environment controls
  bit         auto_credit = 1'b0;
  logic       manual_ret  = 1'b0;
  int         ll_lat      = 1;
  logic [9:0] ll_inc      = 10'h011;
  bit         spur_ll     = 1'b0;
  bit         ack_corrupt = 1'b0;

  assign ed_bm_credit_return = (auto_credit & packet_req) | manual_ret;

  // Link-list memory (next = ptr + 0x011 after ll_lat cycles) and packet memory ack
  int         ll_cnt = 0;
  logic [9:0] ll_nxt = '0;
  logic       pend_v = 1'b0;
  logic [3:0] pend_dst = '0;
  logic       pend_sop = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ll_cnt = 0; ll_rd_valid = 1'b0; ll_rd_next_ptr = '0;
      pend_v = 1'b0; pend_dst = '0; pend_sop = 1'b0;
      packet_ack_data_valid = 1'b0; packet_ack_port_id = '0; packet_ack_sop = 1'b0;
    end else begin
      ll_rd_valid = 1'b0;
      if (ll_cnt > 0) begin
        ll_cnt--;
        if (ll_cnt == 0) begin ll_rd_valid = 1'b1; ll_rd_next_ptr = ll_nxt; end
      end else if (spur_ll) begin
        ll_rd_valid = 1'b1; ll_rd_next_ptr = 10'h2AA;
      end
      if (ll_rd_req) begin ll_cnt = ll_lat; ll_nxt = ll_rd_ptr + ll_inc; end
      packet_ack_data_valid = pend_v;
      packet_ack_port_id    = ack_corrupt ? 4'd3 : pend_dst;
      packet_ack_sop        = pend_sop;
      pend_v   = packet_req;
      pend_dst = packet_req_dst_port_id;
      pend_sop = packet_req_sop;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; manual_ret = 1'b0; tm_bm_desc_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_desc(input logic [3:0] s, input logic [3:0] d,
                           input logic [9:0] p, input logic [13:0] l);
    int k;
    k = 0;
    while (!tm_bm_desc_ready && k < 60) begin @(negedge clk); k++; end
    chk("desc_ready", 64'(tm_bm_desc_ready), 64'd1);
    tm_bm_desc_valid = 1'b1;
    tm_bm_desc_src_port_id = s; tm_bm_desc_dst_port_id = d;
    tm_bm_desc_buf_ptr = p; tm_bm_desc_len = l;
    @(negedge clk);
    tm_bm_desc_valid = 1'b0;
    chk("ready_drop", 64'(tm_bm_desc_ready), 64'd0);
  endtask

  task automatic wait_beat(output int gap, output bit ok);
    gap = 0; ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      gap++;
      if (packet_req) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL beat_timeout: no packet_req within 60 cycles (t=%0t)", $time);
    end
  endtask

  task automatic stall_check(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (packet_req) seen++;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  task automatic count_beats(output int n);
    int idle;
    n = 0; idle = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (packet_req) begin n++; idle = 0; end
      else idle++;
      if (idle >= 15) break;
    end
  endtask

  // Send one descriptor and check every beat against the chain model
  task automatic run_pkt(input logic [3:0] s, input logic [3:0] d, input logic [9:0] p,
                         input logic [13:0] l, input int lat, input int nb,
                         input logic [3:0] lvb);
    int gap; bit ok; bit last; logic [9:0] e_ptr; logic [1:0] e_lsb; int e_gap; bit e_ll;
    ll_lat = lat;
    send_desc(s, d, p, l);
    for (int i = 0; i < nb; i++) begin
      wait_beat(gap, ok);
      if (!ok) return;
      last  = (i == nb - 1);
      e_ptr = p + 10'((i / 4) * 17);
      e_lsb = 2'(i % 4);
      e_gap = (i != 0 && (i % 4) == 0) ? lat + 2 : 1;
      e_ll  = (e_lsb == 2'd3) && !last;
      chk("sop",   64'(packet_req_sop), 64'(i == 0));
      chk("eop",   64'(packet_req_eop), 64'(last));
      chk("vb",    64'(packet_req_valid_bytes), last ? 64'(lvb) : 64'd0);
      chk("ptr",   64'(packet_req_buf_ptr), 64'(e_ptr));
      chk("lsb",   64'(packet_req_buf_ptr_lsb), 64'(e_lsb));
      chk("src",   64'(packet_req_src_port_id), 64'(s));
      chk("dst",   64'(packet_req_dst_port_id), 64'(d));
      chk("gap",   64'(gap), 64'(e_gap));
      chk("ll_req", 64'(ll_rd_req), 64'(e_ll));
      if (e_ll) chk("ll_ptr", 64'(ll_rd_ptr), 64'(e_ptr));
      chk("ready_at_beat", 64'(tm_bm_desc_ready), 64'(last));
    end
  endtask

  typedef struct {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [9:0]  ptr;
    logic [13:0] len;
    int          lat;
    int          nbeats;
    logic [3:0]  last_vb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n, gap; bit ok;

    vecs[0] = '{4'd2, 4'd5, 10'h010, 14'd16,    1, 1,    4'd0};
    vecs[1] = '{4'd1, 4'd7, 10'h020, 14'd65,    3, 5,    4'd1};
    vecs[2] = '{4'd3, 4'd4, 10'h100, 14'd48,    1, 3,    4'd0};
    vecs[3] = '{4'd6, 4'd9, 10'h1F0, 14'd17,    2, 2,    4'd1};
    vecs[4] = '{4'd0, 4'd1, 10'h3FF, 14'd1,     1, 1,    4'd1};
    vecs[5] = '{4'd15, 4'd0, 10'h000, 14'd15,   1, 1,    4'd15};
    vecs[6] = '{4'd8, 4'd12, 10'h050, 14'd200,  2, 13,   4'd8};
    vecs[7] = '{4'd4, 4'd2, 10'h3F0, 14'd16383, 1, 1024, 4'd15};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req",   64'(packet_req), 64'd0);
    chk("rst_ll",    64'(ll_rd_req), 64'd0);
    chk("rst_ready", 64'(tm_bm_desc_ready), 64'd0);
    chk("rst_err",   64'(err_ack_mismatch), 64'd0);
    chk("rst_fields", {28'd0, packet_req_sop, packet_req_eop, packet_req_valid_bytes,
                       packet_req_buf_ptr, packet_req_buf_ptr_lsb, packet_req_src_port_id,
                       packet_req_dst_port_id, ll_rd_ptr}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(tm_bm_desc_ready), 64'd1);

    // Descriptor table with credits returned as beats go out
    auto_credit = 1'b1;
    for (int v = 0; v < 8; v++)
      run_pkt(vecs[v].src, vecs[v].dst, vecs[v].ptr, vecs[v].len,
              vecs[v].lat, vecs[v].nbeats, vecs[v].last_vb);
    repeat (3) @(negedge clk);
    chk("err_clean", 64'(err_ack_mismatch), 64'd0);

    // ll_rd_valid outside LL_WAIT must not move the pointer
    spur_ll = 1'b1;
    repeat (3) @(negedge clk);
    run_pkt(4'd5, 4'd6, 10'h040, 14'd64, 1, 4, 4'd0);
    spur_ll = 1'b0;

    // Credit return at full count saturates
    do_reset();
    auto_credit = 1'b0;
    repeat (3) begin manual_ret = 1'b1; @(negedge clk); end
    manual_ret = 1'b0;
    send_desc(4'd1, 4'd2, 10'h080, 14'd160);
    count_beats(n);
    chk("sat_beats", 64'(n), 64'(ED_CREDITS));

    // Simultaneous request and return leaves the count unchanged
    do_reset();
    auto_credit = 1'b1;
    run_pkt(4'd1, 4'd2, 10'h300, 14'd128, 1, 8, 4'd0);
    @(negedge clk);
    auto_credit = 1'b0;
    send_desc(4'd1, 4'd2, 10'h0C0, 14'd160);
    count_beats(n);
    chk("simul_beats", 64'(n), 64'(ED_CREDITS));

    // Two credits left: 64B packet stalls after two beats, one return gives one beat
    do_reset();
    auto_credit = 1'b0;
    run_pkt(4'd2, 4'd3, 10'h0A0, 14'd96, 1, 6, 4'd0);
    send_desc(4'd7, 4'd8, 10'h200, 14'd64);
    wait_beat(gap, ok);
    chk("cr_b0_lsb", 64'(packet_req_buf_ptr_lsb), 64'd0);
    wait_beat(gap, ok);
    chk("cr_b1_lsb", 64'(packet_req_buf_ptr_lsb), 64'd1);
    stall_check("cr_stall0", 10);
    manual_ret = 1'b1; @(negedge clk); manual_ret = 1'b0;
    wait_beat(gap, ok);
    chk("cr_b2_lsb", 64'(packet_req_buf_ptr_lsb), 64'd2);
    chk("cr_b2_eop", 64'(packet_req_eop), 64'd0);
    stall_check("cr_stall1", 10);
    manual_ret = 1'b1; @(negedge clk); manual_ret = 1'b0;
    wait_beat(gap, ok);
    chk("cr_b3_lsb", 64'(packet_req_buf_ptr_lsb), 64'd3);
    chk("cr_b3_eop", 64'(packet_req_eop), 64'd1);
    chk("cr_b3_vb",  64'(packet_req_valid_bytes), 64'd0);
    chk("cr_b3_ll",  64'(ll_rd_req), 64'd0);
    chk("cr_b3_ptr", 64'(packet_req_buf_ptr), 64'h200);

    // Reset in the middle of a 128B packet
    do_reset();
    auto_credit = 1'b0;
    ll_lat = 2;
    send_desc(4'd3, 4'd4, 10'h140, 14'd128);
    repeat (3) wait_beat(gap, ok);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req",   64'(packet_req), 64'd0);
    chk("mid_rst_ll",    64'(ll_rd_req), 64'd0);
    chk("mid_rst_ready", 64'(tm_bm_desc_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_beats(n);
    chk("mid_rst_no_beats", 64'(n), 64'd0);
    send_desc(4'd3, 4'd4, 10'h180, 14'd128);
    count_beats(n);
    chk("mid_rst_credits", 64'(n), 64'(ED_CREDITS));
    do_reset();
    auto_credit = 1'b1;
    run_pkt(4'd2, 4'd5, 10'h010, 14'd16, 1, 1, 4'd0);

`ifdef BM_PREQ_ACK_CHECK_EN
    // Ack carrying the wrong port id sets the sticky error
    do_reset();
    auto_credit = 1'b1;
    ack_corrupt = 1'b1;
    run_pkt(4'd2, 4'd5, 10'h010, 14'd16, 1, 1, 4'd0);
    repeat (3) @(negedge clk);
    chk("ack_err_set", 64'(err_ack_mismatch), 64'd1);
    ack_corrupt = 1'b0;
    run_pkt(4'd2, 4'd5, 10'h020, 14'd16, 1, 1, 4'd0);
    repeat (3) @(negedge clk);
    chk("ack_err_sticky", 64'(err_ack_mismatch), 64'd1);
    do_reset();
    chk("ack_err_cleared", 64'(err_ack_mismatch), 64'd0);
`else
    repeat (3) @(negedge clk);
    chk("err_tied_low", 64'(err_ack_mismatch), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bm_packet_req_gen.md
Name: bm_packet_req_gen

Overview:
- Initiator side of the buffer-manager packet-read interface: turns dequeued packet descriptors from the traffic manager into per-beat packet_req requests to the shared packet memory.
- Walks each packet beat by beat through its buffer chain, and reads the buffer link list to get the next buffer pointer.
- Sits between the TM descriptor dequeue and the shared packet memory; downstream buffering to ED is throttled by a credit counter.

Parameters:
- PORT_ID_NBITS, 4, port id width
- BUF_PTR_NBITS, 10, buffer pointer width
- BUF_PTR_LSB_NBITS, 2, beat index within a buffer (4 beats per buffer)
- DATA_PATH_NBYTES, 16, bytes per beat
- DATA_PATH_VB_NBITS, 4, valid-bytes width; 0 encodes a full beat (16 bytes)
- LEN_NBITS, 14, packet length in bytes
- ED_CREDITS, 8, initial credit count; credit counter width is clog2(ED_CREDITS+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, the codebase `RESET_SIG net: synchronous, active-high
- tm_bm_desc_valid  in  1  descriptor available
- tm_bm_desc_ready  out  1  descriptor accepted when valid&ready
- tm_bm_desc_src_port_id  in  PORT_ID_NBITS  source port
- tm_bm_desc_dst_port_id  in  PORT_ID_NBITS  destination port
- tm_bm_desc_buf_ptr  in  BUF_PTR_NBITS  first buffer
- tm_bm_desc_len  in  LEN_NBITS  packet length in bytes, 1..2^LEN_NBITS-1
- ll_rd_req  out  1  link-list read strobe, 1 cycle
- ll_rd_ptr  out  BUF_PTR_NBITS  buffer whose successor is requested
- ll_rd_valid  in  1  next pointer returned, latency ≥1
- ll_rd_next_ptr  in  BUF_PTR_NBITS  successor pointer
- ed_bm_credit_return  in  1  one beat freed downstream
- packet_req  out  1  beat read request
- packet_req_src_port_id, packet_req_dst_port_id  out  PORT_ID_NBITS  port ids of the packet
- packet_req_sop, packet_req_eop  out  1  first/last beat
- packet_req_valid_bytes  out  DATA_PATH_VB_NBITS  valid bytes of the beat
- packet_req_buf_ptr  out  BUF_PTR_NBITS  buffer pointer of the beat
- packet_req_buf_ptr_lsb  out  BUF_PTR_LSB_NBITS  beat index within the buffer
- packet_ack_data_valid  in  1  memory ack, arrives 1 cycle after packet_req
- packet_ack_port_id  in  PORT_ID_NBITS  port id of the acked beat
- packet_ack_sop  in  1  sop of the acked beat
- err_ack_mismatch  out  1  sticky ack-check error

Behaviour:
- All outputs are registered.
- Reset values: packet_req, ll_rd_req, tm_bm_desc_ready and err_ack_mismatch = 0; credit counter = ED_CREDITS; FSM = IDLE; all other outputs = 0.
- FSM states: IDLE, BEAT, LL_WAIT.
- IDLE:
  - tm_bm_desc_ready=1.
  - On accept: latch ports, set ptr=buf_ptr, lsb=0, bytes_left=len, first=1.
  - Next state BEAT.
  - Ready drops the cycle after accept; at most one descriptor in flight.
- BEAT:
  - Issue a beat when credit>0: packet_req=1 the next cycle.
  - sop=first; eop=(bytes_left ≤ DATA_PATH_NBYTES).
  - valid_bytes = eop ? bytes_left[VB-1:0] : 0.
  - buf_ptr=ptr, buf_ptr_lsb=lsb.
  - Update bytes_left -= 16 (saturates at 0), first=0, credit-1.
  - If eop → IDLE.
  - Else if lsb is all ones → issue ll_rd_req with ll_rd_ptr=ptr, go to LL_WAIT.
  - Else lsb+1 and stay in BEAT.
  - When credit=0, no request is issued and the state holds.
- LL_WAIT:
  - On ll_rd_valid: ptr=ll_rd_next_ptr, lsb=0 → BEAT.
  - ll_rd_valid seen outside LL_WAIT is ignored.
- Rate: one beat per cycle maximum inside a buffer; every buffer crossing costs the link-list latency plus 1 cycle.
- Credits:
  - A simultaneous request and ed_bm_credit_return leaves the counter unchanged.
  - A return when the counter equals ED_CREDITS saturates (no increment).
- Length boundaries:
  - len=16 → single beat, sop=eop=1, vb=0.
  - len=65 → 5 beats; beat 4 triggers a link-list read; the last beat has vb=1.
- A synchronous reset mid-packet aborts the packet immediately: no further req beats, credits restored to ED_CREDITS.

Optional Feature:
- BM_PREQ_ACK_CHECK_EN defined:
  - A 1-deep shadow of the last issued {req, dst_port_id, sop}.
  - err_ack_mismatch is set sticky when packet_ack_data_valid differs from the shadow req.
  - It is also set when an ack's port_id or sop differs from the shadow.
  - Cleared only by reset.
- Undefined: err_ack_mismatch tied to 0, no shadow registers.

Decomposition:
- Shared package/defines.vh: PORT_ID_NBITS, BUF_PTR_NBITS, BUF_PTR_LSB_NBITS, DATA_PATH_NBYTES, DATA_PATH_VB_NBITS, LEN_NBITS, the FSM state encodings, and a packet_req field struct/bundle.
- One natural sub-module: bm_credit_counter (saturating up/down counter with init value and nonzero flag).

Test Plan:
- Single 16B descriptor (src=2, dst=5, ptr=0x010), credits=8 → one req: sop=1, eop=1, vb=0, ptr=0x010, lsb=0; ack checked; ready returns next cycle.
- 65B packet, ptr=0x020, ll returns 0x031 after 3 cycles →
  - req lsb 0..3 on ptr 0x020;
  - ll_rd_req with ll_rd_ptr=0x020;
  - 5th beat on ptr=0x031, lsb=0, eop=1, vb=1.
- Credits=2, no returns, 64B packet → 2 beats then stall; one credit return → exactly one more beat.
- Back-to-back 48B and 17B descriptors → 3+2 beats; sop on beats 1 and 4; second packet last-beat vb=1.
- Reset asserted in the middle of a 128B packet → req=0 the next cycle, credits=ED_CREDITS; a new 16B packet then completes normally.
- BM_PREQ_ACK_CHECK_EN: ack with port 3 versus issued dst 5 → err_ack_mismatch=1, stays 1 until reset.
